// File: rtl/lif_ctrl_pkg.sv
// Shared state encoding, default sizing and helpers for the LIF neuron
// parameter-load controller.
package lif_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2
    } lif_state_e;

    localparam int DEFAULT_NUM_PARAMS = 4;
    localparam int DEFAULT_PARAM_W    = 8;
    localparam int DEFAULT_TIMEOUT    = 255;
    localparam int LOAD_COUNT_W       = 8;

    // A counter over a single-value range still needs one physical bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/lif_param_shifter.sv
// Parallel-in serial-out register for the parameter frame; the most
// significant bit is presented first and the register shifts left.
module lif_param_shifter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             shift_out
);

    logic [WIDTH-1:0] shift_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= load_data;
        end else if (shift_en) begin
            shift_reg <= shift_reg << 1;
        end
    end

    assign shift_out = shift_reg[WIDTH-1];

endmodule

// File: rtl/lif_param_loader.sv
// Host-to-core configuration controller: collects parameter words, streams
// them serially into the LIF core and waits for the core to acknowledge.
module lif_param_loader
    import lif_ctrl_pkg::*;
#(
    parameter int NUM_PARAMS = DEFAULT_NUM_PARAMS,
    parameter int PARAM_W    = DEFAULT_PARAM_W,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    abort,
    input  logic                    cfg_valid,
    input  logic [PARAM_W-1:0]      cfg_data,
    output logic                    cfg_ready,
    input  logic                    params_ready,
    output logic                    load_mode,
    output logic                    serial_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LOAD_COUNT_W-1:0] load_count
);

    localparam int FRAME_W   = NUM_PARAMS * PARAM_W;
    localparam int WIDX_W    = cnt_width(NUM_PARAMS);
    localparam int BIT_CNT_W = cnt_width(FRAME_W);
    localparam int TIMER_W   = cnt_width(TIMEOUT + 1);

    localparam logic [WIDX_W-1:0]    LAST_WORD  = WIDX_W'(NUM_PARAMS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT   = BIT_CNT_W'(FRAME_W - 1);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    lif_state_e state, state_next;

    logic [WIDX_W-1:0]       word_idx, word_idx_next;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_next;
    logic [TIMER_W-1:0]      timer, timer_next;
    logic [PARAM_W-1:0]      shadow [NUM_PARAMS];
    logic [FRAME_W-1:0]      frame_load;

    logic                    load_mode_next;
    logic                    serial_next;
    logic                    done_next;
    logic                    error_next;
    logic                    cfg_ready_next;
    logic                    busy_next;
    logic [LOAD_COUNT_W-1:0] count_next;

    logic                    accept;
    logic                    shift_load;
    logic                    shift_en;
    logic                    shift_bit;

    assign accept = enable && cfg_valid && cfg_ready && (state == IDLE);

    // Word 0 occupies the top of the frame so it leaves the shifter first;
    // the final word is still on cfg_data when the shifter is loaded.
    always_comb begin
        frame_load = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            frame_load[(NUM_PARAMS-1-i)*PARAM_W +: PARAM_W] =
                (i == NUM_PARAMS - 1) ? cfg_data : shadow[i];
        end
    end

    lif_param_shifter #(
        .WIDTH (FRAME_W)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (shift_load),
        .load_data (frame_load),
        .shift_en  (shift_en),
        .shift_out (shift_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The first SHIFT cycle only raises load_mode with bit 0, so bit_cnt
    // starts counting once a bit is already on the line and the exit cycle
    // is the one after the last bit has been presented.
    always_comb begin
        state_next     = state;
        word_idx_next  = word_idx;
        bit_cnt_next   = bit_cnt;
        timer_next     = timer;
        load_mode_next = load_mode;
        serial_next    = serial_data;
        done_next      = done;
        error_next     = error;
        count_next     = load_count;
        shift_load     = 1'b0;
        shift_en       = 1'b0;

        if (abort) begin
            state_next     = IDLE;
            word_idx_next  = '0;
            bit_cnt_next   = '0;
            timer_next     = '0;
            load_mode_next = 1'b0;
            serial_next    = 1'b0;
            done_next      = 1'b0;
        end else if (enable) begin
            done_next = 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        error_next = 1'b0;
                        if (word_idx == LAST_WORD) begin
                            state_next    = SHIFT;
                            word_idx_next = '0;
                            bit_cnt_next  = '0;
                            shift_load    = 1'b1;
                        end else begin
                            word_idx_next = word_idx + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (load_mode && (bit_cnt == LAST_BIT)) begin
                        state_next     = WAIT_RDY;
                        load_mode_next = 1'b0;
                        serial_next    = 1'b0;
                        timer_next     = '0;
                    end else begin
                        load_mode_next = 1'b1;
                        serial_next    = shift_bit;
                        shift_en       = 1'b1;
                        if (load_mode) begin
                            bit_cnt_next = bit_cnt + 1'b1;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (params_ready) begin
                        state_next = IDLE;
                        timer_next = '0;
                        done_next  = 1'b1;
                        if (load_count != '1) begin
                            count_next = load_count + 1'b1;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state_next = IDLE;
                        timer_next = '0;
                        error_next = 1'b1;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        cfg_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_idx    <= '0;
            bit_cnt     <= '0;
            timer       <= '0;
            load_mode   <= 1'b0;
            serial_data <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            cfg_ready   <= 1'b1;
            busy        <= 1'b0;
            load_count  <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            word_idx    <= word_idx_next;
            bit_cnt     <= bit_cnt_next;
            timer       <= timer_next;
            load_mode   <= load_mode_next;
            serial_data <= serial_next;
            done        <= done_next;
            error       <= error_next;
            cfg_ready   <= cfg_ready_next;
            busy        <= busy_next;
            load_count  <= count_next;
            if (accept && !abort) begin
                shadow[word_idx] <= cfg_data;
            end
        end
    end

endmodule
